gray_monitor: RTL
=================

# gray_monitor

Receive-side companion to the team's 3-bit Gray-code up-counter. It samples a Gray-coded count stream, such as a counter output crossing into another block, and registers the binary value of each sample. It checks that every sample either holds the previous code or advances exactly one Gray step, and reports wrap-arounds and sequence violations.

## Interface
- W, 3, width of Gray code and binary output (W >= 2)
- WC, 8, width of wrap counter
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset; clock Clk
- In_valid  input  1  Gray_in is sampled on this cycle when high
- Gray_in  input  W  Gray-coded count sample
- Bin_out  output  W  registered binary value of last accepted sample
- Out_valid  output  1  one-cycle pulse: Bin_out updated this cycle
- Wrap  output  1  one-cycle pulse: last sample wrapped max -> 0
- Wrap_count  output  WC  number of wraps, saturating at 2^WC-1
- Locked  output  1  high while in LOCKED state
- Step_err  output  1  sticky: illegal step detected; cleared only by Reset

## Operation
- Decode (combinational, internal): b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i] for i = W-2 down to 0.
- Internal registers: prev_bin (W bits), FSM state.
- FSM states: UNLOCKED (reset state), LOCKED, ERROR.
- UNLOCKED, In_valid=1:
  - Capture the decoded sample into prev_bin and Bin_out.
  - Pulse Out_valid and go to LOCKED. Any code is accepted.
  - No Wrap and no error check on this first sample.
- LOCKED, In_valid=1, with d = decoded sample. Cases are checked in this order:
  - d == prev_bin (hold): pulse Out_valid; Bin_out is unchanged; no Wrap.
  - d == prev_bin + 1 (mod 2^W): legal step. Update prev_bin and Bin_out, and pulse Out_valid.
    - If prev_bin == 2^W-1 and d == 0, also pulse Wrap and increment Wrap_count. Wrap_count stays at 2^WC-1 once saturated.
  - Anything else (skip, backward step, multi-bit Gray change): set Step_err and go to ERROR.
    - Bin_out and prev_bin still take d, and Out_valid pulses.
    - No Wrap on this sample, even if d == 0.
- ERROR, In_valid=1:
  - Decode continues: Bin_out takes d and Out_valid pulses.
  - No checking, no Wrap, Wrap_count is frozen.
  - The FSM stays in ERROR until Reset.
- Any state, In_valid=0: no register changes; Out_valid=0, Wrap=0.
- Locked = (state == LOCKED), registered.

## Timing
- Latency: a sample presented with In_valid at edge N appears on Bin_out, Out_valid, Wrap, Step_err and the state after edge N (one cycle).
- Back-to-back In_valid is supported every cycle. No backpressure.
- Reset takes priority over In_valid on the same edge.
- Reset values: Bin_out=0, Out_valid=0, Wrap=0, Wrap_count=0, Locked=0, Step_err=0, prev_bin=0, state=UNLOCKED.
- Reset mid-stream: the next valid sample after reset is a fresh lock sample, never an error.
- Wrap and Out_valid assert in the same cycle. Step_err rises in the same cycle as the offending Out_valid.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Full cycle, W=3: Reset, then valid samples 000,001,011,010,110,111,101,100,000.
  - Bin_out = 0..7 then 0.
  - Wrap pulses once, with the last sample; Wrap_count=1; Locked=1; Step_err=0.
- Hold and gaps: sample 011 twice, then idle 3 cycles, then 010.
  - Out_valid pulses 3 times; Bin_out = 2,2,3.
  - No error; outputs are stable during the idle cycles.
- Illegal skip: after lock on 001, sample 010 (bin 3).
  - Step_err=1, Locked=0, Bin_out=3.
  - A following 110 gives Bin_out=4, Step_err stays 1 and Wrap_count is unchanged.
- Lock on non-zero code: first sample after reset is 110.
  - Bin_out=4, Locked=1, no error.
  - Then 111 and 101 give Bin_out 5 and 6.
- Reset mid-operation: in ERROR with Wrap_count=1, assert Reset together with In_valid.
  - All outputs return to 0 and state is UNLOCKED; the coincident sample is ignored.
  - The next sample 100 locks with Bin_out=7.
- Saturation, WC=2: run 5 full wraps.
  - Wrap_count reads 1,2,3,3,3.
  - Wrap still pulses on every wrap.

Source files
------------

// File: rtl/gray_monitor_if.sv
// Sample stream and status bundle between a Gray-count source and gray_monitor.
// The source side drives the sample; the monitor side returns decoded value and status.
interface gray_monitor_if #(
    parameter int W  = 3,
    parameter int WC = 8
);
    logic          In_valid;
    logic [W-1:0]  Gray_in;
    logic [W-1:0]  Bin_out;
    logic          Out_valid;
    logic          Wrap;
    logic [WC-1:0] Wrap_count;
    logic          Locked;
    logic          Step_err;

    modport master (
        output In_valid, Gray_in,
        input  Bin_out, Out_valid, Wrap, Wrap_count, Locked, Step_err
    );

    modport slave (
        input  In_valid, Gray_in,
        output Bin_out, Out_valid, Wrap, Wrap_count, Locked, Step_err
    );
endinterface

// File: rtl/gray_monitor.sv
// Decodes a sampled Gray count to binary and checks that each sample holds or
// advances exactly one step; reports wraps and sticky sequence violations.
module gray_monitor #(
    parameter int W  = 3,
    parameter int WC = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    gray_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  prev_bin;
    logic [W-1:0]  d;
    logic          is_hold;
    logic          is_step;

    logic [W-1:0]  prev_next;
    logic [W-1:0]  bin_next;
    logic          out_valid_next;
    logic          wrap_next;
    logic [WC-1:0] wrap_count_next;
    logic          step_err_next;
    logic          locked_next;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign d       = gray2bin(bus.Gray_in);
    assign is_hold = (d == prev_bin);
    assign is_step = (d == prev_bin + W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (bus.In_valid) begin
            unique case (state)
                UNLOCKED: state_next = LOCKED;
                LOCKED:   if (!is_hold && !is_step) state_next = ERROR;
                ERROR:    state_next = ERROR;
                default:  state_next = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        prev_next       = prev_bin;
        bin_next        = bus.Bin_out;
        out_valid_next  = 1'b0;
        wrap_next       = 1'b0;
        wrap_count_next = bus.Wrap_count;
        step_err_next   = bus.Step_err;
        if (bus.In_valid) begin
            out_valid_next = 1'b1;
            unique case (state)
                UNLOCKED: begin
                    prev_next = d;
                    bin_next  = d;
                end
                LOCKED: begin
                    if (is_step) begin
                        prev_next = d;
                        bin_next  = d;
                        // A legal step landing on zero can only come from the all-ones code.
                        if (d == '0) begin
                            wrap_next = 1'b1;
                            if (bus.Wrap_count != '1) begin
                                wrap_count_next = bus.Wrap_count + WC'(1);
                            end
                        end
                    end else if (!is_hold) begin
                        prev_next     = d;
                        bin_next      = d;
                        step_err_next = 1'b1;
                    end
                end
                ERROR: begin
                    prev_next = d;
                    bin_next  = d;
                end
                default: begin
                    prev_next = prev_bin;
                end
            endcase
        end
        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_bin       <= '0;
            bus.Bin_out    <= '0;
            bus.Out_valid  <= 1'b0;
            bus.Wrap       <= 1'b0;
            bus.Wrap_count <= '0;
            bus.Locked     <= 1'b0;
            bus.Step_err   <= 1'b0;
        end else begin
            prev_bin       <= prev_next;
            bus.Bin_out    <= bin_next;
            bus.Out_valid  <= out_valid_next;
            bus.Wrap       <= wrap_next;
            bus.Wrap_count <= wrap_count_next;
            bus.Locked     <= locked_next;
            bus.Step_err   <= step_err_next;
        end
    end
endmodule
